// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: regfile write-port arbiter (A/B) with busy scoreboard; define RF_WB_RR_EN for round-robin, else fixed A priority
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_reg,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_reg,
  input  logic [DATA_W-1:0] b_data,
  input  logic              rsv_valid,
  input  logic [ADDR_W-1:0] rsv_reg,
  input  logic [ADDR_W-1:0] chk_reg1,
  input  logic [ADDR_W-1:0] chk_reg2,
  output logic              busy1,
  output logic              busy2,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              write_enable
);
  localparam int N = 2 ** ADDR_W;
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};
  logic              grant_a, grant_b;
  logic [ADDR_W-1:0] write_reg_q, write_reg_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic              write_enable_q, write_enable_d;
  logic [N-1:0]      busy_q, busy_d, set_v, clr_v;
`ifdef RF_WB_RR_EN
  logic              last_b_q, last_b_d;
`endif

  // Grants are held low in reset; a new reservation overrides a same-edge completing write; entry 0 never busy
  always_comb begin
`ifdef RF_WB_RR_EN
    grant_a = rst_n & a_valid & (~b_valid | last_b_q);
`else
    grant_a = rst_n & a_valid;
`endif
    grant_b = rst_n & b_valid & ~grant_a;
`ifdef RF_WB_RR_EN
    last_b_d = grant_a ? 1'b0 : grant_b ? 1'b1 : last_b_q;
`endif
    write_reg_d = grant_a ? a_reg : grant_b ? b_reg : write_reg_q;
    write_data_d = grant_a ? a_data : grant_b ? b_data : write_data_q;
    write_enable_d = (grant_a | grant_b) & (write_reg_d != '0);
    set_v = rsv_valid ? (ONE << rsv_reg) : '0;
    clr_v = write_enable_q ? (ONE << write_reg_q) : '0;
    busy_d = ((busy_q & ~clr_v) | set_v) & ~ONE;
  end

  // Output beat register and scoreboard; reset pointer favours A
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_reg_q <= '0;
      write_data_q <= '0;
      write_enable_q <= 1'b0;
      busy_q <= '0;
`ifdef RF_WB_RR_EN
      last_b_q <= 1'b1;
`endif
    end else begin
      write_reg_q <= write_reg_d;
      write_data_q <= write_data_d;
      write_enable_q <= write_enable_d;
      busy_q <= busy_d;
`ifdef RF_WB_RR_EN
      last_b_q <= last_b_d;
`endif
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;
  assign busy1 = busy_q[chk_reg1];
  assign busy2 = busy_q[chk_reg2];
  assign write_reg = write_reg_q;
  assign write_data = write_data_q;
  assign write_enable = write_enable_q;
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and scoreboard for the 32x32 register file's single write port. It shares that port between two requesters, the ALU result path (A) and the load/memory result path (B), using valid/ready handshakes, and registers the winning beat onto the regfile write interface. It also keeps a 32-bit busy scoreboard of destination registers with reserved, uncommitted writes, which issue logic uses to stall on read-after-write hazards.

## Interface

Parameters:
- DATA_W, 32, write data width
- ADDR_W, 5, register index width; the scoreboard has 2**ADDR_W entries

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- a_valid  in  1  requester A has a write-back beat
- a_ready  out  1  beat A accepted this cycle
- a_reg  in  ADDR_W  destination register for A
- a_data  in  DATA_W  write data for A
- b_valid, b_ready, b_reg, b_data: same as the A ports, for requester B
- rsv_valid  in  1  reserve a destination register (instruction issue)
- rsv_reg  in  ADDR_W  register to mark busy
- chk_reg1  in  ADDR_W  first source register to check
- chk_reg2  in  ADDR_W  second source register to check
- busy1  out  1  chk_reg1 has a pending write
- busy2  out  1  chk_reg2 has a pending write
- write_reg  out  ADDR_W  regfile write index, registered
- write_data  out  DATA_W  regfile write data, registered
- write_enable  out  1  regfile write strobe, registered

Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).

## Operation

- Grant is combinational from the valid inputs.
  - Only one requester valid: it is granted.
  - Both valid: the arbitration policy decides (see Configuration).
- Ready is a pure grant: a_ready = grant_a, b_ready = grant_b. At most one ready is high in any cycle.
- A beat transfers when valid && ready. The requester holds reg and data stable until it is accepted.
- Output register:
  - The accepted beat loads write_reg and write_data.
  - write_enable = 1 only if the accepted reg != 0.
  - With no transfer, write_enable = 0 and write_reg/write_data hold their previous values.
  - The regfile always accepts, so the output never back-pressures.
- Scoreboard busy[i]:
  - Set on the edge where rsv_valid && rsv_reg == i && i != 0.
  - Cleared on the edge that ends a cycle with write_enable && write_reg == i. That is the same edge on which the regfile commits the data.
  - busy[0] is constantly 0.
- busy1 = busy[chk_reg1] and busy2 = busy[chk_reg2], combinational.
- Same-edge set and clear of one register: set wins. A new reservation overrides the completing older write.
- Reserving a register that is already busy leaves it busy. There is no count; issue logic stalls on WAW using the busy outputs.
- A write to a register that is not busy is still performed, and busy is unaffected.

## Timing

- Reset (asynchronous assert, synchronous release):
  - write_enable = 0, write_reg = 0, write_data = 0
  - busy[] all 0
  - Round-robin pointer favours A.
- Latency:
  - Accept edge to write_enable high: 1 cycle.
  - Accept to regfile commit: 2 edges.
  - Accept to busy clear visible on busy1/busy2: 2 edges.
- Throughput: one write-back per cycle. The losing requester waits at least one cycle.
- Reset mid-operation clears any pending output beat. No write reaches the regfile after rst_n falls.

## Configuration

- RF_WB_RR_EN defined: round-robin arbitration.
  - A 1-bit last-grant pointer records the most recent grant.
  - On a tie, the requester not granted last wins.
  - The pointer updates only on a granted transfer.
- RF_WB_RR_EN undefined: fixed priority, A always wins ties. B can starve while A is continuously valid.

## Test plan

- Reset: hold rst_n=0 with both valids high -> a_ready=b_ready=0, write_enable=0, busy1=busy2=0.
- Single write: rsv reg 5; next cycle A valid, reg 5, data 0xDEADBEEF.
  - Required response: a_ready=1, and one cycle later write_enable=1, write_reg=5, write_data=0xDEADBEEF.
  - busy1 (chk_reg1=5) is 1 until the edge after the write_enable cycle, then 0.
- Contention, 4 cycles with both valid (A reg 1, B reg 2):
  - Without RF_WB_RR_EN: A is granted every cycle and b_ready stays 0.
  - With RF_WB_RR_EN: grants alternate A, B, A, B.
- Register 0: B valid, reg 0, data 0x1234 -> b_ready=1, write_enable stays 0; busy1 with chk_reg1=0 is 0 after rsv_valid on reg 0.
- Simultaneous set and clear: reg 7 busy with its write_enable cycle in progress, and rsv_valid with rsv_reg=7 in that same cycle -> busy[7] remains 1 after the edge.
- Async reset mid-stream: drop rst_n while write_enable=1 -> write_enable goes 0 immediately (before the next clk edge), and all busy bits clear.
